// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the stream framing constants.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word_ready/word_data are combinational on the handshake of the fourth byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word_data
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;

  // The top byte is never stored: it completes the word directly.
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    word_ready = 1'b0;
    word_data  = {byte_data, asm_q};
    if (byte_vld) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    asm_d[7:0]   = byte_data;
        2'd1:    asm_d[15:8]  = byte_data;
        2'd2:    asm_d[23:16] = byte_data;
        default: word_ready   = (cnt_q == 2'(BYTES_PER_WORD - 1));
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      asm_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image into instruction memory and releases the
// core from reset only after the payload checksum has been verified.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [7:0]        csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              core_reset_q, core_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic              word_ready;
  logic [31:0]       word_data;

  assign hs = in_valid & in_ready_q;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_vld   (hs && (state_q == DATA)),
    .byte_data  (in_data),
    .word_ready (word_ready),
    .word_data  (word_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_lo_d  = cnt_lo_q;
    n_d       = n_q;
    widx_d    = widx_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      HDR0: if (hs) begin
        cnt_lo_d = in_data;
        state_d  = HDR1;
      end
      HDR1: if (hs) begin
        n_d = {in_data, cnt_lo_q};
        // Full-width compare so counts such as 0x0140 are not aliased.
        if ({1'b0, n_d} > 17'(DEPTH))  state_d = ERROR;
        else if (n_d == 16'd0)         state_d = CSUM;
        else                           state_d = DATA;
      end
      DATA: if (hs) begin
        csum_d = csum_q ^ in_data;
        if (word_ready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = widx_q[ADDR_W-1:0];
          wr_data_d = word_data;
          widx_d    = widx_q + 1'b1;
          if (16'(widx_d) == n_q) state_d = CSUM;
        end
      end
      CSUM: if (hs) begin
        state_d = (in_data == csum_q) ? RUN : ERROR;
      end
      default: ;
    endcase
    in_ready_d   = (state_d != RUN) && (state_d != ERROR);
    done_d       = (state_d == RUN);
    err_d        = (state_d == ERROR);
    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HDR0;
      cnt_lo_q     <= 8'd0;
      n_q          <= 16'd0;
      widx_q       <= '0;
      csum_q       <= 8'd0;
      in_ready_q   <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      csum_q       <= csum_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed streams plus random images checked
// against a stream-level reference model.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_reset;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // observed writes
  int          wa_q[$];
  logic [31:0] wd_q[$];
  // per-byte observations from the driver
  bit rdy_q[$];
  bit done_q[$];
  bit err_q[$];
  bit cr_q[$];
  // reference model results
  int          exp_a[$];
  logic [31:0] exp_d[$];
  bit          exp_done, exp_err;
  int          exp_acc;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(wr_data);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic drive_stream(input logic [7:0] s[$], input bit gaps);
    rdy_q.delete(); done_q.delete(); err_q.delete(); cr_q.delete();
    foreach (s[i]) begin
      int idle;
      idle = (gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (idle) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
      rdy_q.push_back(in_ready);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      done_q.push_back(done);
      err_q.push_back(err);
      cr_q.push_back(core_reset);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference model: decodes the framed stream as a whole.
  task automatic model(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    exp_a.delete(); exp_d.delete();
    n = int'({s[1], s[0]});
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
      exp_acc = HDR_BYTES;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      int b;
      b = HDR_BYTES + BYTES_PER_WORD * w;
      exp_a.push_back(w);
      exp_d.push_back({s[b+3], s[b+2], s[b+1], s[b]});
      x = x ^ s[b] ^ s[b+1] ^ s[b+2] ^ s[b+3];
    end
    exp_acc  = HDR_BYTES + BYTES_PER_WORD * n + 1;
    exp_done = (s[exp_acc-1] == x);
    exp_err  = !exp_done;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (wr_en !== 1'b0)      begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== '0)      begin failures++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wr_data !== 32'd0)   begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_single_word();
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'h60, 8'h00, 8'hA0, 8'hE3, 8'h23, 8'h55, 8'hAA};
    do_reset();
    drive_stream(s, 1'b0);
    checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL single_wr_count got=%0d exp=1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] != 0) begin failures++; $display("FAIL single_wr_addr got=%0d exp=0", wa_q[0]); end
      checks++; if (wd_q[0] !== 32'hE3A00060) begin failures++; $display("FAIL single_wr_data got=%h exp=e3a00060", wd_q[0]); end
    end
    checks++; if (done_q[5] !== 1'b0 || done_q[6] !== 1'b1) begin failures++; $display("FAIL single_done_timing got=%b%b exp=01", done_q[5], done_q[6]); end
    checks++; if (err_q[6] !== 1'b0 || cr_q[6] !== 1'b0) begin failures++; $display("FAIL single_err_cr got=%b%b exp=00", err_q[6], cr_q[6]); end
    checks++; if (rdy_q[7] !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL single_in_ready_after got=%b%b exp=00", rdy_q[7], in_ready); end
    checks++; if (done !== 1'b1 || core_reset !== 1'b0) begin failures++; $display("FAIL single_sticky got=%b%b exp=10", done, core_reset); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'h60, 8'h00, 8'hA0, 8'hE3, 8'h24, 8'h00};
    do_reset();
    drive_stream(s, 1'b0);
    checks++; if (err_q[5] !== 1'b0 || err_q[6] !== 1'b1) begin failures++; $display("FAIL badcsum_err_timing got=%b%b exp=01", err_q[5], err_q[6]); end
    checks++; if (done !== 1'b0 || core_reset !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL badcsum_final got=d%b cr%b e%b exp=d0 cr1 e1", done, core_reset, err); end
    checks++; if (wa_q.size() != 1 || wd_q[0] !== 32'hE3A00060) begin failures++; $display("FAIL badcsum_write got_count=%0d exp=1 word e3a00060", wa_q.size()); end
  endtask

  task automatic test_oversize();
    logic [7:0] s[$] = '{8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    drive_stream(s, 1'b0);
    checks++; if (err_q[0] !== 1'b0 || err_q[1] !== 1'b1) begin failures++; $display("FAIL oversize_err_timing got=%b%b exp=01", err_q[0], err_q[1]); end
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL oversize_writes got=%0d exp=0", wa_q.size()); end
    checks++; if (rdy_q[2] !== 1'b0 || core_reset !== 1'b1) begin failures++; $display("FAIL oversize_ready_cr got=%b%b exp=01", rdy_q[2], core_reset); end
  endtask

  task automatic test_gaps();
    logic [7:0] s[$] = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                         8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    for (int r = 0; r < 3; r++) begin
      do_reset();
      drive_stream(s, 1'b1);
      checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL gaps_wr_count got=%0d exp=2", wa_q.size()); end
      else begin
        checks++; if (wa_q[0] != 0 || wd_q[0] !== 32'h1) begin failures++; $display("FAIL gaps_word0 got=%0d:%h exp=0:00000001", wa_q[0], wd_q[0]); end
        checks++; if (wa_q[1] != 1 || wd_q[1] !== 32'h2) begin failures++; $display("FAIL gaps_word1 got=%0d:%h exp=1:00000002", wa_q[1], wd_q[1]); end
      end
      checks++; if (done_q[10] !== 1'b1 || done_q[9] !== 1'b0) begin failures++; $display("FAIL gaps_done got=%b%b exp=01", done_q[9], done_q[10]); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] p[$] = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'h60, 8'h00, 8'hA0, 8'hE3, 8'h23};
    do_reset();
    drive_stream(p, 1'b0);
    do_reset();
    checks++; if (in_ready !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL midreset_state got=r%b cr%b d%b exp=r1 cr1 d0", in_ready, core_reset, done); end
    drive_stream(s, 1'b0);
    checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL midreset_wr_count got=%0d exp=1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] != 0 || wd_q[0] !== 32'hE3A00060) begin failures++; $display("FAIL midreset_word got=%0d:%h exp=0:e3a00060", wa_q[0], wd_q[0]); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL midreset_done got=%b exp=1", done); end
  endtask

  task automatic test_zero_length();
    logic [7:0] s[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    drive_stream(s, 1'b0);
    checks++; if (done_q[2] !== 1'b1 || done_q[1] !== 1'b0) begin failures++; $display("FAIL zero_done got=%b%b exp=01", done_q[1], done_q[2]); end
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wa_q.size()); end
  endtask

  task automatic test_random_images();
    for (int it = 0; it < 10; it++) begin
      logic [7:0] s[$];
      int n;
      logic [7:0] x;
      bit ok;
      case (it)
        0:       n = DEPTH;
        1:       n = DEPTH + 1 + int'($urandom_range(0, 1000));
        2:       n = int'($urandom_range(256, 65535));
        default: n = int'($urandom_range(0, DEPTH));
      endcase
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      x = 8'h00;
      if (n <= DEPTH) begin
        for (int b = 0; b < BYTES_PER_WORD * n; b++) begin
          logic [7:0] v;
          v = 8'($urandom);
          s.push_back(v);
          x ^= v;
        end
        s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
      end
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      model(s);
      do_reset();
      drive_stream(s, it[0]);
      checks++; if (wa_q.size() != exp_a.size()) begin failures++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", it, wa_q.size(), exp_a.size()); end
      else begin
        ok = 1'b1;
        foreach (exp_a[k]) if (wa_q[k] != exp_a[k] || wd_q[k] !== exp_d[k]) ok = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL rand%0d_wr_content got=mismatched words exp=model words (n=%0d)", it, n); end
      end
      checks++; if (done_q[exp_acc-1] !== exp_done || err_q[exp_acc-1] !== exp_err) begin failures++; $display("FAIL rand%0d_terminal got=d%b e%b exp=d%b e%b", it, done_q[exp_acc-1], err_q[exp_acc-1], exp_done, exp_err); end
      checks++; if (done_q[exp_acc-2] !== 1'b0 || err_q[exp_acc-2] !== 1'b0) begin failures++; $display("FAIL rand%0d_early got=d%b e%b exp=d0 e0", it, done_q[exp_acc-2], err_q[exp_acc-2]); end
      ok = 1'b1;
      foreach (rdy_q[k]) if (rdy_q[k] !== (k < exp_acc)) ok = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_in_ready got=wrong pattern exp=1 for %0d bytes then 0", it, exp_acc); end
      checks++; if (core_reset !== !exp_done || done !== exp_done || err !== exp_err) begin failures++; $display("FAIL rand%0d_final got=cr%b d%b e%b exp=cr%b d%b e%b", it, core_reset, done, err, !exp_done, exp_done, exp_err); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_oversize();
    test_gaps();
    test_reset_mid_load();
    test_zero_length();
    test_random_images();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
